wl_frame_ctl: RTL and testbench
===============================

# wl_frame_ctl

Frame sequencer for the canny pixel pipeline. Brings an asynchronous software enable into the `clk` domain, arms on it, and starts a frame on the sensor frame-start pulse. It then counts valid pixels into column/row coordinates, flags start-of-frame/end-of-line/end-of-frame, and holds the pipeline enabled for a fixed drain period after the last pixel. It sits between the pixel source and the filter/gradient/NMS stages and is their single source of frame timing.

## Interface
Parameters:
- IMG_W, 640, active pixels per line (≥2)
- IMG_H, 480, active lines per frame (≥2)
- PIPE_LAT, 16, drain cycles after last pixel (≥1)
- CW, 12, column/row counter width; must hold max(IMG_W,IMG_H)-1

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_b  in  1  asynchronous, active-low reset
- en_a  in  1  enable level from another domain, asynchronous; synchronized internally
- vs  in  1  frame-start pulse, synchronous to clk, one cycle
- pix_vld  in  1  upstream pixel valid, synchronous to clk
- pix_vld_o  out  1  registered pixel valid forwarded to pipeline
- col  out  CW  column of current pix_vld_o pixel
- row  out  CW  row of current pix_vld_o pixel
- sof  out  1  with first pixel of frame
- eol  out  1  with last pixel of each line
- eof  out  1  with last pixel of frame
- pipe_en  out  1  pipeline clock-enable: high in ACTIVE and FLUSH
- busy  out  1  high in ACTIVE, FLUSH, DONE
- frame_done  out  1  one-cycle pulse when drain completes
- err_short  out  1  sticky short-frame flag (see Configuration)

## Operation
- en_a passes through a two-flop synchronizer to become en_s; only en_s is used.
- States: IDLE, ARM, ACTIVE, FLUSH, DONE.
- IDLE: en_s=1 -> ARM.
- ARM: en_s=0 -> IDLE. vs=1 -> ACTIVE with col=row=0 pending.
- ACTIVE: each pix_vld cycle emits pix_vld_o with current col/row.
  - col increments and wraps IMG_W-1 -> 0, incrementing row.
  - The pixel at col=IMG_W-1, row=IMG_H-1 asserts eof and moves to FLUSH.
  - pix_vld=0 cycles stall the counters; pipe_en stays 1.
- FLUSH: down-counter loaded with PIPE_LAT-1 at entry; pix_vld ignored; at 0 -> DONE.
- DONE: frame_done=1 for one cycle; -> ARM if en_s=1, else IDLE.
- en_s falling in ACTIVE/FLUSH: current frame completes normally; the DONE exit then goes to IDLE.
- vs outside ARM and ACTIVE is ignored.
- vs and pix_vld in the same ARM cycle: that pix_vld is not counted; counting starts the next cycle.
- sof: row=0, col=0. eol: col=IMG_W-1. eof: eol with row=IMG_H-1. All qualified by pix_vld_o.
- Counters compare against IMG_W-1/IMG_H-1 and never exceed them.

## Timing
- Reset: state IDLE, en_s synchronizer flops 0, all outputs 0, counters 0.
- en_a -> en_s latency: 2 clk edges. IDLE -> ARM takes effect on the third edge.
- pix_vld -> pix_vld_o/col/row/sof/eol/eof: 1 cycle, all registered.
- pipe_en rises the cycle after vs is sampled in ARM. It falls the cycle after FLUSH ends.
- pipe_en is high for exactly PIPE_LAT cycles after the eof cycle.
- frame_done is asserted PIPE_LAT+1 cycles after eof.
- Asynchronous reset mid-frame aborts immediately to reset values. No partial-frame flags are issued.

## Configuration
- WL_FRMCTL_ERR_EN defined:
  - vs in ACTIVE sets sticky err_short.
  - The frame restarts: col=row=0, state stays ACTIVE.
  - err_short clears only on reset or the IDLE -> ARM transition.
- Undefined:
  - vs in ACTIVE is ignored.
  - err_short is tied 0.

## Structure
- Shared package wl_frame_pkg holds:
  - the state enum (IDLE, ARM, ACTIVE, FLUSH, DONE)
  - default IMG_W/IMG_H/PIPE_LAT constants, used by downstream line buffers
- Sub-module: the existing two-stage register synchronizer wl_regd2, instantiated with DW=1 on en_a.
- FSM, counters and flag registers are local.

## Test plan
Bench uses IMG_W=4, IMG_H=3, PIPE_LAT=5.
- Reset held then released, en_a=0, vs pulsed -> state IDLE, all outputs 0, no pix_vld_o.
- en_a=1, vs, 12 consecutive pix_vld -> col 0,1,2,3 repeating; row 0,0,0,0,1…2; sof on pixel 0; eol on pixels 3,7,11; eof on pixel 11; pipe_en 5 cycles past eof; frame_done 6 cycles after eof; back in ARM.
- Same frame with pix_vld=0 every other cycle -> identical col/row/flag sequence; counters hold during gaps.
- en_a dropped after pixel 5 -> frame completes, frame_done pulses, state IDLE; next vs ignored.
- With WL_FRMCTL_ERR_EN, vs after pixel 6 -> err_short=1 sticky; next pixel reports col=0, row=0 with sof. Without the macro, the frame continues to pixel 11.
- rst_b asserted during FLUSH -> all outputs 0 immediately; no frame_done pulse after release.

Source files
------------

// File: rtl/wl_frame_pkg.sv
// wl_frame_pkg: shared frame-sequencer state encoding and default image geometry
package wl_frame_pkg;
   localparam int IMG_W_D    = 640;
   localparam int IMG_H_D    = 480;
   localparam int PIPE_LAT_D = 16;
   typedef enum logic [2:0] {IDLE, ARM, ACTIVE, FLUSH, DONE} state_t;
endpackage

// File: rtl/wl_regd2.sv
// wl_regd2: two-stage register synchronizer for signals entering the clk domain
module wl_regd2 import wl_frame_pkg::*; #(
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);
   logic [DW-1:0] m;
   // two back-to-back flops give metastability settling time
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         m <= '0;
         q <= '0;
      end else begin
         m <= d;
         q <= m;
      end
endmodule

// File: rtl/wl_frame_ctl.sv
// wl_frame_ctl: frame sequencer (arm, count pixels, flag sof/eol/eof, drain); WL_FRMCTL_ERR_EN enables short-frame restart and err_short
module wl_frame_ctl import wl_frame_pkg::*; #(
   parameter int IMG_W    = IMG_W_D,
   parameter int IMG_H    = IMG_H_D,
   parameter int PIPE_LAT = PIPE_LAT_D,
   parameter int CW       = 12
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          en_a,
   input  logic          vs,
   input  logic          pix_vld,
   output logic          pix_vld_o,
   output logic [CW-1:0] col,
   output logic [CW-1:0] row,
   output logic          sof,
   output logic          eol,
   output logic          eof,
   output logic          pipe_en,
   output logic          busy,
   output logic          frame_done,
   output logic          err_short
);
   localparam int FW = $clog2(PIPE_LAT) + 1;
   state_t        st, st_nx;
   logic          en_s, rst_frm, acc, last_c, last_r;
   logic [CW-1:0] c_cnt, r_cnt;
   logic [FW-1:0] f_cnt;
   wl_regd2 #(.DW(1)) u_sync (.clk(clk), .rst_b(rst_b), .d(en_a), .q(en_s));
`ifdef WL_FRMCTL_ERR_EN
   assign rst_frm = (st == ACTIVE) && vs;
`else
   assign rst_frm = 1'b0;
`endif
   assign acc    = (st == ACTIVE) && pix_vld && !rst_frm;
   assign last_c = c_cnt == CW'(IMG_W - 1);
   assign last_r = r_cnt == CW'(IMG_H - 1);
   // state register
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) st <= IDLE;
      else st <= st_nx;
   // next state: the last pixel ends the frame, drain then returns to ARM only if still enabled
   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    st_nx = en_s ? ARM : IDLE;
         ARM:     st_nx = !en_s ? IDLE : vs ? ACTIVE : ARM;
         ACTIVE:  st_nx = (acc && last_c && last_r) ? FLUSH : ACTIVE;
         FLUSH:   st_nx = (f_cnt == '0) ? DONE : FLUSH;
         DONE:    st_nx = en_s ? ARM : IDLE;
         default: st_nx = IDLE;
      endcase
   end
   // coordinate counters advance on accepted pixels; drain counter stays loaded until FLUSH
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         c_cnt <= '0;
         r_cnt <= '0;
         f_cnt <= '0;
      end else begin
         if ((st == ARM && vs) || rst_frm) begin
            c_cnt <= '0;
            r_cnt <= '0;
         end else if (acc) begin
            c_cnt <= last_c ? '0 : c_cnt + 1'b1;
            r_cnt <= !last_c ? r_cnt : last_r ? '0 : r_cnt + 1'b1;
         end
         f_cnt <= (st == FLUSH) ? f_cnt - FW'(1) : FW'(PIPE_LAT - 1);
      end
   // registered pixel outputs, one cycle behind pix_vld
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         pix_vld_o <= 1'b0;
         col       <= '0;
         row       <= '0;
         sof       <= 1'b0;
         eol       <= 1'b0;
         eof       <= 1'b0;
      end else begin
         pix_vld_o <= acc;
         col       <= acc ? c_cnt : col;
         row       <= acc ? r_cnt : row;
         sof       <= acc && c_cnt == '0 && r_cnt == '0;
         eol       <= acc && last_c;
         eof       <= acc && last_c && last_r;
      end
`ifdef WL_FRMCTL_ERR_EN
   // sticky short-frame flag, cleared when re-arming from IDLE
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) err_short <= 1'b0;
      else if (st == IDLE && en_s) err_short <= 1'b0;
      else if (rst_frm) err_short <= 1'b1;
`else
   assign err_short = 1'b0;
`endif
   // state-decoded pipeline controls
   always_comb begin
      pipe_en    = st == ACTIVE || st == FLUSH;
      busy       = st == ACTIVE || st == FLUSH || st == DONE;
      frame_done = st == DONE;
   end
endmodule

// File: tb/tb_wl_frame_ctl.sv
// tb_wl_frame_ctl: directed bench with a pixel-index model checked every cycle plus literal frame expectations
module tb_wl_frame_ctl;
   localparam int W = 4, H = 3, L = 5, CW = 4;
`ifdef WL_FRMCTL_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif
   logic clk = 1'b0, rst_b = 1'b0, en_a = 1'b0, vs = 1'b0, pix_vld = 1'b0;
   logic pix_vld_o, sof, eol, eof, pipe_en, busy, frame_done, err_short;
   logic [CW-1:0] col, row;
   int checks = 0, errors = 0, dn = 0;
   int qc[$], qr[$], qf[$];
   int md, k, t, pe, ec, er, esof, eeol, eeof, eerr;
   logic es1, es2;
   int lc[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
   int lr[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
   int lf[12] = '{4, 0, 0, 2, 0, 0, 0, 2, 0, 0, 0, 3};

   wl_frame_ctl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(L), .CW(CW)) dut (
      .clk(clk), .rst_b(rst_b), .en_a(en_a), .vs(vs), .pix_vld(pix_vld),
      .pix_vld_o(pix_vld_o), .col(col), .row(row), .sof(sof), .eol(eol), .eof(eof),
      .pipe_en(pipe_en), .busy(busy), .frame_done(frame_done), .err_short(err_short)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
      end
   endtask

   // model: mode 0 idle, 1 armed, 2 in frame (k pixels taken), 3 draining (t cycles left), 4 done
   always @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         md = 0; k = 0; t = 0; pe = 0; ec = 0; er = 0;
         esof = 0; eeol = 0; eeof = 0; eerr = 0; es1 = 0; es2 = 0;
      end else begin
         pe = 0; esof = 0; eeol = 0; eeof = 0;
         case (md)
            0: if (es2) begin md = 1; eerr = 0; end
            1: if (!es2) md = 0; else if (vs) begin md = 2; k = 0; end
            2: if (ERR && vs) begin eerr = 1; k = 0; end
               else if (pix_vld) begin
                  pe = 1; ec = k % W; er = k / W;
                  esof = int'(k == 0); eeol = int'(k % W == W - 1); eeof = int'(k == W * H - 1);
                  k++;
                  if (k == W * H) begin md = 3; t = L; end
               end
            3: begin t--; if (t == 0) md = 4; end
            default: md = es2 ? 1 : 0;
         endcase
         es2 = es1; es1 = en_a;
      end

   always @(negedge clk) begin
      chk("pix_vld_o", int'(pix_vld_o), pe);
      if (pe != 0) begin
         chk("col", int'(col), ec);
         chk("row", int'(row), er);
      end
      chk("sof", int'(sof), esof);
      chk("eol", int'(eol), eeol);
      chk("eof", int'(eof), eeof);
      chk("pipe_en", int'(pipe_en), int'(md == 2 || md == 3));
      chk("busy", int'(busy), int'(md >= 2));
      chk("frame_done", int'(frame_done), int'(md == 4));
      chk("err_short", int'(err_short), eerr);
      if (frame_done) dn++;
      if (pix_vld_o) begin
         qc.push_back(int'(col));
         qr.push_back(int'(row));
         qf.push_back(int'({sof, eol, eof}));
      end
   end

   task automatic step(input logic v, input logic p);
      vs = v; pix_vld = p;
      @(posedge clk); #1;
      vs = 1'b0; pix_vld = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0, pc = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (pipe_en) pc++;
         if (frame_done) break;
      end
      chk({tag, "_done_lat"}, n, 6);
      chk({tag, "_pipe_len"}, pc, 5);
      @(posedge clk); #1;
   endtask

   task automatic frame(input string tag, input bit gap, input int drop_after);
      qc.delete(); qr.delete(); qf.delete();
      step(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         if (gap) step(1'b0, 1'b0);
         step(1'b0, 1'b1);
         if (i == drop_after) en_a = 1'b0;
      end
      wait_done(tag);
      chk({tag, "_npix"}, qc.size(), 12);
      for (int i = 0; i < 12; i++) begin
         chk({tag, "_lit_col"}, i < qc.size() ? qc[i] : -1, lc[i]);
         chk({tag, "_lit_row"}, i < qr.size() ? qr[i] : -1, lr[i]);
         chk({tag, "_lit_flag"}, i < qf.size() ? qf[i] : -1, lf[i]);
      end
   endtask

   initial begin
      int d0;
      repeat (3) @(posedge clk);
      #3 rst_b = 1'b1;
      @(posedge clk); #1;
      qc.delete();
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("idle_npix", qc.size(), 0);
      chk("idle_busy", int'(busy), 0);
      en_a = 1'b1;
      repeat (3) step(1'b0, 1'b0);
      frame("f1", 1'b0, -1);
      frame("gap", 1'b1, -1);
      frame("drop", 1'b0, 5);
      qc.delete();
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("drop_vs_ignored", qc.size(), 0);
      chk("drop_busy", int'(busy), 0);
      en_a = 1'b1;
      repeat (3) step(1'b0, 1'b0);
      qc.delete(); qr.delete(); qf.delete();
      step(1'b1, 1'b0);
      repeat (7) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      repeat (ERR ? 12 : 5) step(1'b0, 1'b1);
      wait_done("err");
      chk("err_next_col", qc.size() > 7 ? qc[7] : -1, ERR ? 0 : 3);
      chk("err_next_row", qr.size() > 7 ? qr[7] : -1, ERR ? 0 : 1);
      chk("err_next_flag", qf.size() > 7 ? qf[7] : -1, ERR ? 4 : 2);
      chk("err_sticky", int'(err_short), int'(ERR));
      step(1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      #2 rst_b = 1'b0;
      #1;
      chk("rst_pipe_en", int'(pipe_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pix_vld_o", int'(pix_vld_o), 0);
      chk("rst_err", int'(err_short), 0);
      d0 = dn;
      @(posedge clk);
      #3 rst_b = 1'b1;
      repeat (20) @(posedge clk);
      chk("rst_no_done", dn, d0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
